// File: rtl/golomb_search_controller.sv
// rtl/golomb_search_controller.sv - step sequencer for the Golomb ruler mark chain
// Issues one globalready strobe per step, evaluates the nominated level, and tightens limit on each complete ruler.
module golomb_search_controller #(
  parameter int NUMPOSITIONS = 5,
  parameter int VALW         = 9,
  parameter int IDXW         = 3,
  parameter int SETTLE       = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [VALW-1:0]                init_limit,
  input  logic                           level_ready,
  input  logic [IDXW-1:0]                next_enabled,
  input  logic [(NUMPOSITIONS+1)*VALW-1:0] marks,
  output logic [IDXW-1:0]                enabled,
  output logic                           globalready,
  output logic [VALW-1:0]                limit,
  output logic                           solution_valid,
  output logic [(NUMPOSITIONS+1)*VALW-1:0] solution_marks,
  output logic [7:0]                     solution_count,
  output logic [31:0]                    step_count,
  output logic                           busy,
  output logic                           done
);

  localparam int MW = (NUMPOSITIONS+1)*VALW;
  localparam logic [IDXW-1:0] LAST_LEVEL = IDXW'(NUMPOSITIONS);
  localparam logic [IDXW-1:0] COMPLETE   = IDXW'(NUMPOSITIONS+1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] enabled_q, enabled_d;
  logic            globalready_q, globalready_d;
  logic [VALW-1:0] limit_q, limit_d;
  logic            solution_valid_q, solution_valid_d;
  logic [MW-1:0]   solution_marks_q, solution_marks_d;
  logic [7:0]      solution_count_q, solution_count_d;
  logic [31:0]     step_count_q, step_count_d;
  logic [2:0]      wait_q, wait_d;

  always_comb begin
    state_d          = state_q;
    enabled_d        = enabled_q;
    limit_d          = limit_q;
    solution_valid_d = 1'b0;
    solution_marks_d = solution_marks_q;
    solution_count_d = solution_count_q;
    step_count_d     = step_count_q;
    wait_d           = wait_q;

    if (abort) begin
      state_d   = S_IDLE;
      enabled_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            limit_d          = init_limit;
            enabled_d        = IDXW'(1);
            solution_count_d = '0;
            step_count_d     = '0;
            solution_marks_d = '0;
            state_d          = S_ISSUE;
          end
        end
        S_ISSUE: begin
          step_count_d = step_count_q + 32'd1;
          wait_d       = 3'(SETTLE);
          state_d      = S_WAIT;
        end
        S_WAIT: begin
          if (wait_q != 3'd0) wait_d = wait_q - 3'd1;
          // The last settle cycle and any stalled cycles after it may advance.
          if (wait_q <= 3'd1 && level_ready) state_d = S_EVAL;
        end
        S_EVAL: begin
          if (next_enabled == '0 || next_enabled > COMPLETE) begin
            enabled_d = '0;
            state_d   = S_DONE;
          end else if (next_enabled == COMPLETE) begin
            solution_marks_d = marks;
            limit_d          = marks[VALW-1:0];
            solution_valid_d = 1'b1;
            if (solution_count_q != 8'hFF) solution_count_d = solution_count_q + 8'd1;
            enabled_d        = LAST_LEVEL;
            state_d          = S_ISSUE;
          end else begin
            enabled_d = next_enabled;
            state_d   = S_ISSUE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Registered strobe: high for exactly the cycle spent in ISSUE.
    globalready_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      enabled_q        <= '0;
      globalready_q    <= 1'b0;
      limit_q          <= '0;
      solution_valid_q <= 1'b0;
      solution_marks_q <= '0;
      solution_count_q <= '0;
      step_count_q     <= '0;
      wait_q           <= '0;
    end else begin
      state_q          <= state_d;
      enabled_q        <= enabled_d;
      globalready_q    <= globalready_d;
      limit_q          <= limit_d;
      solution_valid_q <= solution_valid_d;
      solution_marks_q <= solution_marks_d;
      solution_count_q <= solution_count_d;
      step_count_q     <= step_count_d;
      wait_q           <= wait_d;
    end
  end

  assign enabled        = enabled_q;
  assign globalready    = globalready_q;
  assign limit          = limit_q;
  assign solution_valid = solution_valid_q;
  assign solution_marks = solution_marks_q;
  assign solution_count = solution_count_q;
  assign step_count     = step_count_q;
  assign busy           = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_EVAL);
  assign done           = (state_q == S_DONE);

endmodule

// File: tb/tb_golomb_search_controller.sv
// tb/tb_golomb_search_controller.sv - directed bench for golomb_search_controller
// Stub marks are driven directly; expected values are hand-computed for SETTLE=2.
module tb_golomb_search_controller;

  localparam int NP   = 5;
  localparam int VALW = 9;
  localparam int IDXW = 3;
  localparam int MW   = (NP+1)*VALW;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [VALW-1:0] init_limit = '0;
  logic            level_ready = 1'b1;
  logic [IDXW-1:0] next_enabled = '0;
  logic [MW-1:0]   marks = '0;
  logic [IDXW-1:0] enabled;
  logic            globalready;
  logic [VALW-1:0] limit;
  logic            solution_valid;
  logic [MW-1:0]   solution_marks;
  logic [7:0]      solution_count;
  logic [31:0]     step_count;
  logic            busy;
  logic            done;

  int tests_run = 0;
  int tests_failed = 0;
  int pulses;

  golomb_search_controller #(.NUMPOSITIONS(NP), .VALW(VALW), .IDXW(IDXW), .SETTLE(2)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .init_limit(init_limit),
    .level_ready(level_ready), .next_enabled(next_enabled), .marks(marks),
    .enabled(enabled), .globalready(globalready), .limit(limit),
    .solution_valid(solution_valid), .solution_marks(solution_marks),
    .solution_count(solution_count), .step_count(step_count), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check("rst_enabled", 64'(enabled), 64'd0);
    check("rst_globalready", 64'(globalready), 64'd0);
    check("rst_limit", 64'(limit), 64'd0);
    check("rst_busy_done", 64'({busy, done}), 64'd0);
    check("rst_counts", 64'({solution_count, step_count}), 64'd0);

    // Step through levels 1..5; the fifth evaluation nominates level 6 (complete ruler).
    init_limit   = 9'd20;
    marks        = {9'd0, 9'd1, 9'd4, 9'd10, 9'd12, 9'd17};
    start        = 1'b1;
    cyc();
    start        = 1'b0;
    check("start_globalready", 64'(globalready), 64'd1);
    check("start_enabled", 64'(enabled), 64'd1);
    check("start_limit", 64'(limit), 64'd20);
    check("start_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 5; k++) begin
      next_enabled = IDXW'(k + 2);
      pulses = 0;
      for (int c = 0; c < 3; c++) begin
        cyc();
        if (globalready) pulses++;
      end
      cyc();
      check($sformatf("period_gr_%0d", k), 64'({pulses[3:0], globalready}), 64'h01);
      if (k < 4) check($sformatf("enabled_step_%0d", k), 64'(enabled), 64'(k + 2));
    end
    check("sol_valid", 64'(solution_valid), 64'd1);
    check("sol_limit", 64'(limit), 64'd17);
    check("sol_count", 64'(solution_count), 64'd1);
    check("sol_enabled", 64'(enabled), 64'd5);
    check("sol_step_count", 64'(step_count), 64'd5);
    check("sol_marks", 64'(solution_marks), 64'({9'd0, 9'd1, 9'd4, 9'd10, 9'd12, 9'd17}));

    // Stall in WAIT with level_ready low.
    level_ready = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (globalready) pulses++;
      if (c == 0) check("sol_valid_pulse", 64'(solution_valid), 64'd0);
    end
    check("stall_no_gr", 64'(pulses), 64'd0);
    check("stall_busy", 64'(busy), 64'd1);
    next_enabled = '0;
    level_ready  = 1'b1;
    cyc();
    check("stall_release_gr", 64'(globalready), 64'd0);
    cyc();
    check("exhaust_done_busy", 64'({done, busy}), 64'b10);
    check("exhaust_enabled", 64'(enabled), 64'd0);
    check("exhaust_held", 64'({limit, solution_count}), 64'({9'd17, 8'd1}));

    // Restart from DONE, then abort in the same cycle as a complete-ruler EVAL.
    init_limit   = 9'd30;
    next_enabled = 3'd3;
    start        = 1'b1;
    cyc();
    start        = 1'b0;
    check("restart_counts", 64'({solution_count, step_count}), 64'd0);
    check("restart_state", 64'({enabled, limit, done}), 64'({3'd1, 9'd30, 1'b0}));
    cyc(); cyc(); cyc();
    abort        = 1'b1;
    next_enabled = 3'd6;
    cyc();
    abort        = 1'b0;
    check("abort_outputs", 64'({enabled, globalready, busy, done, solution_valid}), 64'd0);
    check("abort_held", 64'({limit, solution_count}), 64'({9'd30, 8'd0}));
    check("abort_step_count", 64'(step_count), 64'd1);

    // Out-of-range nomination is treated as exhaustion.
    next_enabled = 3'd7;
    start        = 1'b1;
    cyc();
    start        = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    check("overrange_done", 64'({done, busy, enabled}), 64'({1'b1, 1'b0, 3'd0}));

    // Asynchronous reset in WAIT with enabled=3.
    next_enabled = 3'd3;
    start        = 1'b1;
    cyc();
    start        = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    cyc();
    check("pre_reset_enabled", 64'(enabled), 64'd3);
    #2 reset = 1'b1;
    #1;
    check("async_rst_enabled", 64'(enabled), 64'd0);
    check("async_rst_outputs", 64'({globalready, busy, done, limit, solution_count, step_count}), 64'd0);
    cyc(); cyc();
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (globalready) pulses++;
    end
    check("post_reset_no_gr", 64'(pulses), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
